// File: rtl/imm_splitter.sv
// imm_splitter: breaks a full-width constant into the shortest sequence of raw
// immediate fields (each tagged with its immSel code) that a downstream
// extender plus shift-and-OR accumulator rebuilds into the original value.
// Short constants go out as a single I or J beat. Wider constants go out as
// HI (J) / MID (J) / LO (I) beats. All outputs are registered.
module imm_splitter #(
    parameter int DATA_WIDTH    = 36,
    parameter int SELECT_WIDTH  = 2,
    parameter int IMM_MAX_WIDTH = 14,
    parameter int I_IMM_WIDTH   = 8,
    parameter int J_IMM_WIDTH   = 14
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [DATA_WIDTH-1:0]    i_value,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [IMM_MAX_WIDTH-1:0] o_immRaw,
    output logic [SELECT_WIDTH-1:0]  o_immSel,
    output logic                     o_first,
    output logic                     o_last,
    output logic                     o_valid,
    input  logic                     i_ready
);

    // immSel codes understood by the downstream extender.
    localparam logic [SELECT_WIDTH-1:0] IMMSEL_NONE = SELECT_WIDTH'(0);
    localparam logic [SELECT_WIDTH-1:0] IMMSEL_I    = SELECT_WIDTH'(1);
    localparam logic [SELECT_WIDTH-1:0] IMMSEL_J    = SELECT_WIDTH'(2);

    // Only the bits below the HI field are needed after the accept cycle.
    localparam int LOW_WIDTH = DATA_WIDTH - J_IMM_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SINGLE,
        S_HI,
        S_MID,
        S_LO
    } state_t;

    state_t                   state_q, state_d;
    logic                     valid_q, valid_d;
    logic [IMM_MAX_WIDTH-1:0] raw_q, raw_d;
    logic [SELECT_WIDTH-1:0]  sel_q, sel_d;
    logic                     first_q, first_d;
    logic                     last_q, last_d;
    logic [LOW_WIDTH-1:0]     value_q, value_d;

    logic accept;
    logic consume;
    logic fits_i;
    logic fits_j;

    // A value fits a field when every bit from the field's sign bit upward
    // is a copy of that sign bit.
    logic [DATA_WIDTH-I_IMM_WIDTH:0] top_i;
    logic [DATA_WIDTH-J_IMM_WIDTH:0] top_j;

    assign top_i  = i_value[DATA_WIDTH-1:I_IMM_WIDTH-1];
    assign top_j  = i_value[DATA_WIDTH-1:J_IMM_WIDTH-1];
    assign fits_i = (&top_i) | ~(|top_i);
    assign fits_j = (&top_j) | ~(|top_j);

    // Ready when idle, or when the final beat of the current constant leaves
    // this cycle, so back-to-back constants need no bubble.
    assign o_ready = (state_q == S_IDLE) | (valid_q & i_ready & last_q);
    assign accept  = i_valid & o_ready;
    assign consume = valid_q & i_ready;

    assign o_valid  = valid_q;
    assign o_immRaw = raw_q;
    assign o_immSel = sel_q;
    assign o_first  = first_q;
    assign o_last   = last_q;

    // Next-state and next-beat selection.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        valid_d = valid_q;
        raw_d   = raw_q;
        sel_d   = sel_q;
        first_d = first_q;
        last_d  = last_q;
        value_d = value_q;

        if (accept) begin
            // Accept can only occur while idle or on the last beat's consume,
            // so a new constant always takes priority over advancing.
            valid_d = 1'b1;
            value_d = i_value[LOW_WIDTH-1:0];
            if (fits_i) begin
                state_d = S_SINGLE;
                raw_d   = IMM_MAX_WIDTH'(i_value[I_IMM_WIDTH-1:0]);
                sel_d   = IMMSEL_I;
                first_d = 1'b1;
                last_d  = 1'b1;
            end else if (fits_j) begin
                state_d = S_SINGLE;
                raw_d   = IMM_MAX_WIDTH'(i_value[J_IMM_WIDTH-1:0]);
                sel_d   = IMMSEL_J;
                first_d = 1'b1;
                last_d  = 1'b1;
            end else begin
                state_d = S_HI;
                raw_d   = IMM_MAX_WIDTH'(i_value[DATA_WIDTH-1 -: J_IMM_WIDTH]);
                sel_d   = IMMSEL_J;
                first_d = 1'b1;
                last_d  = 1'b0;
            end
        end else if (consume) begin
            case (state_q)
                S_HI: begin
                    state_d = S_MID;
                    raw_d   = IMM_MAX_WIDTH'(value_q[I_IMM_WIDTH +: J_IMM_WIDTH]);
                    sel_d   = IMMSEL_J;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                end
                S_MID: begin
                    state_d = S_LO;
                    raw_d   = IMM_MAX_WIDTH'(value_q[I_IMM_WIDTH-1:0]);
                    sel_d   = IMMSEL_I;
                    first_d = 1'b0;
                    last_d  = 1'b1;
                end
                default: begin
                    // SINGLE or LO beat left with nothing new behind it.
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    raw_d   = '0;
                    sel_d   = IMMSEL_NONE;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                end
            endcase
        end
    end

    // Control state and the registered output beat; reset abandons any
    // constant in flight.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (i_rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            raw_q   <= '0;
            sel_q   <= IMMSEL_NONE;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            raw_q   <= raw_d;
            sel_q   <= sel_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    // Captured low bits of the constant for the MID and LO beats.
    always_ff @(posedge i_clk) begin
        // NOTE: pure datapath storage is left unreset; it is only read in
        // states that are entered through an accept, which loads it first.
        value_q <= value_d;
    end

endmodule

// File: doc/imm_splitter.md
Name: imm_splitter

Overview:
- Reverse direction of the immediate extender: takes a full DATA_WIDTH constant and emits the minimum sequence of raw immediate fields, each tagged with an immSel code.
- A downstream extender, together with a shift-and-OR accumulator, rebuilds the original value from that sequence.
- Used by the constant-load path, which feeds I/J immediate fields into the instruction stream.
- Valid/ready handshake on both sides; the output is registered, with a multi-beat FSM for constants wider than a J field.

Parameters:
- DATA_WIDTH, 36, constant width. Must equal 2*J_IMM_WIDTH + I_IMM_WIDTH.
- SELECT_WIDTH, 2, width of the immSel code.
- IMM_MAX_WIDTH, 14, width of the raw immediate field.
- I_IMM_WIDTH, 8, I-type immediate width.
- J_IMM_WIDTH, 14, J-type immediate width.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_value  input  DATA_WIDTH  constant to encode.
- i_valid  input  1  i_value is valid.
- o_ready  output  1  block accepts i_value this cycle.
- o_immRaw  output  IMM_MAX_WIDTH  raw immediate field of the current beat.
- o_immSel  output  SELECT_WIDTH  immSel code for the beat, using the IMMSEL_* macros from opcode_defs.vh (NONE=00, I=01, J=10).
- o_first  output  1  beat is the first of its constant.
- o_last  output  1  beat is the last of its constant.
- o_valid  output  1  beat valid.
- i_ready  input  1  consumer takes the beat this cycle.

Behaviour:
- Clock and reset: one clock (i_clk); reset (i_rst) is synchronous and active-high.
- Reset values: state=IDLE, o_valid=0, o_immRaw=0, o_immSel=IMMSEL_NONE, o_first=0, o_last=0. o_ready=1 in the cycle after reset.
- Handshakes:
  - Input accepted when i_valid & o_ready.
  - Output beat consumed when o_valid & i_ready.
- o_ready definition: o_ready = (state==IDLE) | (o_valid & i_ready & o_last). This allows back-to-back constants with no bubble.
- Classification, done on the accept cycle from i_value:
  - FITS_I: bits [DATA_WIDTH-1:I_IMM_WIDTH-1] all equal. Single beat, sel=I, raw = zero-padded [I_IMM_WIDTH-1:0].
  - else FITS_J: bits [DATA_WIDTH-1:J_IMM_WIDTH-1] all equal. Single beat, sel=J, raw = [J_IMM_WIDTH-1:0].
  - else SPLIT: three beats.
    - HI: sel=J, raw = [35:22].
    - MID: sel=J, raw = [21:8].
    - LO: sel=I, raw = zero-padded [7:0].
- Reconstruction contract for the consumer: acc = ((signext(HI) << 14) | MID_raw) << 8 | LO_raw. The MID and LO raw fields are used unsigned.
- FSM states: IDLE, SINGLE, HI, MID, LO.
  - IDLE --accept--> SINGLE (FITS_I/FITS_J) or HI (SPLIT).
  - SINGLE --consume--> IDLE, or directly to SINGLE/HI if a new input is accepted the same cycle.
  - HI --consume--> MID --consume--> LO.
  - LO --consume--> IDLE, or to a new constant's first state if accepted the same cycle.
- Latency: the first beat appears the cycle after accept (o_valid registered).
- Beat flags:
  - o_first=1 on SINGLE and HI beats.
  - o_last=1 on SINGLE and LO beats.
- The constant is captured in an internal register at accept; i_value is don't-care afterwards.
- Backpressure: while o_valid & !i_ready, all outputs hold stable and o_ready=0 (unless in IDLE).
- No beat is dropped or duplicated.
- Sign boundaries:
  - -128 and 127 are FITS_I; 128 and -129 are FITS_J.
  - -8192 and 8191 are FITS_J; 8192 and -8193 are SPLIT.
- Reset mid-sequence: the current constant is abandoned. The next cycle is IDLE with o_valid=0, and no partial beats follow.
- i_valid while busy (not IDLE, no last-beat consume): ignored; the source must hold i_valid.

Test Plan:
- Accept 36'h000000005 with i_ready=1 -> one beat the next cycle: raw=14'h0005, sel=01, first=1, last=1; o_ready=1 in the same cycle.
- Accept 36'hFFFFFFF80 (-128), then 36'h000000080 (128) -> beat raw=14'h0080 sel=01; then beat raw=14'h0080 sel=10.
- Accept 36'h000001FFF, then 36'h000002000 -> first gives a single J beat raw=14'h1FFF. Second gives three beats: (14'h0000,10,first), (14'h0020,10), (14'h0000,01,last).
- Accept 36'h123456789 -> beats (14'h048D,sel 10,first=1), (14'h0567,sel 10), (14'h0089,sel 01,last=1); consumer reconstruction equals the input.
- Same constant with i_ready held low 3 cycles on the MID beat -> MID outputs stable all 3 cycles, o_ready=0. LO follows one cycle after i_ready rises. A new i_valid on the LO-consume cycle produces its first beat the next cycle.
- Assert i_rst for 1 cycle after the HI beat is consumed -> next cycle o_valid=0, o_ready=1. A fresh 36'h000000001 then yields a single I beat with no stale MID/LO beats.
